// File: rtl/eqmon_pkg.sv
// Shared types and default sizing for the equivalence monitor.
// No logic of its own, so no latency.
// No flow control; it only holds constants and the state type.
package eqmon_pkg;

  // Run-control states of the monitor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2,
    PASS = 2'd3
  } state_t;

  localparam int EQMON_N_CYC_DEF = 1000;
  localparam int EQMON_CYC_W_DEF = 16;
  localparam int EQMON_CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; it holds at all-ones instead of wrapping.
// The count is registered, so it changes one cycle after an inc.
// No backpressure; clr takes priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up by one per inc and stop at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/equiv_monitor.sv
// Compares out1 against out2 for N_CYC cycles; latches pass/fail plus a mismatch count and first-fail stamp.
// All flags are registered, so they appear one cycle after the edge that decides them.
// No backpressure; start is only accepted in IDLE and clr always wins. EQMON_HIST_EN adds the 16-bit hist port.
module equiv_monitor
  import eqmon_pkg::*;
#(
  parameter int N_CYC = EQMON_N_CYC_DEF,
  parameter int CYC_W = EQMON_CYC_W_DEF,
  parameter int CNT_W = EQMON_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             out1,
  input  logic             out2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CYC_W-1:0] first_fail_cyc
`ifdef EQMON_HIST_EN
  ,
  output logic [15:0]      hist
`endif
);

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(N_CYC - 1);
  localparam logic [CYC_W-1:0] END_CYC  = CYC_W'(N_CYC);

  state_t           state_q;
  state_t           state_d;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_d;
  logic             mism;
  logic             comparing;
  logic             run_start;

  assign mism      = out1 ^ out2;
  // After a failure we keep comparing until the full window has been covered.
  assign comparing = (state_q == RUN) || ((state_q == FAIL) && (cyc_q != END_CYC));
  assign run_start = (state_q == IDLE) && start && !clr;

  // Next-state and cycle-index selection.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    if (clr) begin
      state_d = IDLE;
      cyc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            cyc_d   = '0;
          end
        end
        RUN: begin
          cyc_d = cyc_q + CYC_W'(1);
          // A mismatch on the final cycle must still end in FAIL.
          if (mism) begin
            state_d = FAIL;
          end else if (cyc_q == LAST_CYC) begin
            state_d = PASS;
          end
        end
        FAIL: begin
          if (cyc_q != END_CYC) begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, cycle index and the output flags, all decoded from the next state so they are pure registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      busy    <= (state_d == RUN) || (state_d == FAIL);
      done    <= (state_d == PASS) || ((state_d == FAIL) && (cyc_d == END_CYC));
      pass    <= (state_d == PASS);
      fail    <= (state_d == FAIL);
    end
  end

  // Stamp the index of the first mismatching cycle; later mismatches leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_fail_cyc <= '0;
    end else if (clr || run_start) begin
      first_fail_cyc <= '0;
    end else if ((state_q == RUN) && mism) begin
      first_fail_cyc <= cyc_q;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_mismatch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr || run_start),
    .inc (comparing && mism && !clr),
    .cnt (mismatch_cnt)
  );

`ifdef EQMON_HIST_EN
  // Shift in {out1,out2} while running; stops after the failing pair has been captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (clr || run_start) begin
      hist <= '0;
    end else if (state_q == RUN) begin
      hist <= {hist[13:0], out1, out2};
    end
  end
`endif

endmodule
